// File: rtl/sextium_io_fifo_port_if.sv
// Core IO handshake plus external RX/TX stream signals for sextium_io_fifo_port.
// slave = port block side, master = core/stream driver side.
interface sextium_io_fifo_port_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic             io_read;
  logic             io_write;
  logic [WIDTH-1:0] io_bus_out;
  logic [WIDTH-1:0] io_bus_in;
  logic             ioack;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CW-1:0]    rx_count;
  logic [CW-1:0]    tx_count;

  modport slave (
    input  io_read, io_write, io_bus_out, rx_data, rx_valid, tx_ready,
    output io_bus_in, ioack, rx_ready, tx_data, tx_valid, rx_count, tx_count
  );

  modport master (
    output io_read, io_write, io_bus_out, rx_data, rx_valid, tx_ready,
    input  io_bus_in, ioack, rx_ready, tx_data, tx_valid, rx_count, tx_count
  );
endinterface

// File: rtl/sextium_io_fifo_port.sv
// Core IO port with RX/TX FIFOs, programmable ack latency and back-pressure.
// SEXTIUM_IO_LOOPBACK_EN: core writes go into RX, external RX and TX are disabled.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no request in progress; delay counter preloaded
// RWAIT  | read request: count down delay, wait for RX data
// WWAIT  | write request: count down delay, wait for destination room
// ACK    | ioack high for one cycle
// HOLD   | wait for the core to drop its request
module sextium_io_fifo_port #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int ACK_DELAY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  sextium_io_fifo_port_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RWAIT, S_WWAIT, S_ACK, S_HOLD} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_dly;
  logic [WIDTH-1:0] r_bus_in;

  logic [WIDTH-1:0] r_rx_mem [DEPTH];
  logic [AW-1:0]    r_rx_wr, r_rx_rd;
  logic [CW-1:0]    r_rx_count;
  logic             w_rx_push, w_rx_pop;
  logic [WIDTH-1:0] w_rx_wdata;

  logic             w_core_push;
  logic             w_dst_ok;

`ifdef SEXTIUM_IO_LOOPBACK_EN
  assign w_dst_ok     = (r_rx_count != FULL);
  assign w_rx_push    = w_core_push;
  assign w_rx_wdata   = bus.io_bus_out;
  assign bus.rx_ready = 1'b0;
  assign bus.tx_data  = '0;
  assign bus.tx_valid = 1'b0;
  assign bus.tx_count = '0;
`else
  logic [WIDTH-1:0] r_tx_mem [DEPTH];
  logic [AW-1:0]    r_tx_wr, r_tx_rd;
  logic [CW-1:0]    r_tx_count;
  logic             w_tx_pop;

  assign w_dst_ok     = (r_tx_count != FULL);
  assign bus.rx_ready = (r_rx_count != FULL);
  assign w_rx_push    = bus.rx_valid && bus.rx_ready;
  assign w_rx_wdata   = bus.rx_data;
  assign bus.tx_valid = (r_tx_count != '0);
  assign bus.tx_data  = r_tx_mem[r_tx_rd];
  assign bus.tx_count = r_tx_count;
  assign w_tx_pop     = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge i_clk) begin
    if (w_core_push) r_tx_mem[r_tx_wr] <= bus.io_bus_out;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_core_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)    r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_core_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= w_rx_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // Full/empty decisions use registered counts, so a same-cycle pop never frees room for a push.
  always_comb begin
    w_next      = r_state;
    w_rx_pop    = 1'b0;
    w_core_push = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.io_read)       w_next = S_RWAIT;
        else if (bus.io_write) w_next = S_WWAIT;
      end
      S_RWAIT: begin
        if (!bus.io_read) w_next = S_IDLE;
        else if (r_dly == '0 && r_rx_count != '0) begin
          w_rx_pop = 1'b1;
          w_next   = S_ACK;
        end
      end
      S_WWAIT: begin
        if (!bus.io_write) w_next = S_IDLE;
        else if (r_dly == '0 && w_dst_ok) begin
          w_core_push = 1'b1;
          w_next      = S_ACK;
        end
      end
      S_ACK:   w_next = S_HOLD;
      S_HOLD:  if (!(bus.io_read || bus.io_write)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_dly    <= '0;
      r_bus_in <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE)   r_dly <= 4'(ACK_DELAY);
      else if (r_dly != '0)    r_dly <= r_dly - 1'b1;
      if (w_rx_pop) r_bus_in <= r_rx_mem[r_rx_rd];
    end
  end

  assign bus.ioack     = (r_state == S_ACK);
  assign bus.io_bus_in = r_bus_in;
  assign bus.rx_count  = r_rx_count;
endmodule

// File: tb/tb_sextium_io_fifo_port.sv
// Directed bench for sextium_io_fifo_port: DUT a (ACK_DELAY=0) and DUT b (ACK_DELAY=3).
module tb_sextium_io_fifo_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sextium_io_fifo_port_if #(.WIDTH(16), .DEPTH(8)) a_if ();
  sextium_io_fifo_port_if #(.WIDTH(16), .DEPTH(8)) b_if ();

  sextium_io_fifo_port #(.WIDTH(16), .DEPTH(8), .ACK_DELAY(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(a_if.slave));
  sextium_io_fifo_port #(.WIDTH(16), .DEPTH(8), .ACK_DELAY(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b_if.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_push_a(input logic [15:0] d);
    a_if.rx_data  = d;
    a_if.rx_valid = 1'b1;
    @(negedge clk);
    a_if.rx_valid = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [15:0] exp_d, input int exp_cnt);
    a_if.io_read = 1'b1;
    @(negedge clk);
    chk({tag, "_ack_early"}, a_if.ioack, 0);
    @(negedge clk);
    chk({tag, "_ack"}, a_if.ioack, 1);
    chk({tag, "_data"}, a_if.io_bus_in, exp_d);
    chk({tag, "_rxcnt"}, a_if.rx_count, exp_cnt);
    a_if.io_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic write_a(input string tag, input logic [15:0] d, input int exp_cnt, input bit lb);
    a_if.io_write   = 1'b1;
    a_if.io_bus_out = d;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_ack"}, a_if.ioack, 1);
    if (lb) chk({tag, "_rxcnt"}, a_if.rx_count, exp_cnt);
    else    chk({tag, "_txcnt"}, a_if.tx_count, exp_cnt);
    a_if.io_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;
    {a_if.io_read, a_if.io_write, a_if.rx_valid, a_if.tx_ready} = '0;
    {b_if.io_read, b_if.io_write, b_if.rx_valid, b_if.tx_ready} = '0;
    a_if.io_bus_out = '0; a_if.rx_data = '0;
    b_if.io_bus_out = '0; b_if.rx_data = '0;

    @(negedge clk);
    chk("rst_ioack", a_if.ioack, 0);
    chk("rst_bus_in", a_if.io_bus_in, 0);
    chk("rst_tx_valid", a_if.tx_valid, 0);
    chk("rst_rx_count", a_if.rx_count, 0);
    chk("rst_tx_count", a_if.tx_count, 0);
`ifdef SEXTIUM_IO_LOOPBACK_EN
    chk("rst_rx_ready", a_if.rx_ready, 0);
`else
    chk("rst_rx_ready", a_if.rx_ready, 1);
`endif
    rst_n = 1'b1;
    @(negedge clk);

`ifdef SEXTIUM_IO_LOOPBACK_EN
    rx_push_a(16'h0011);
    chk("lb_ext_push_ignored", a_if.rx_count, 0);
    write_a("lb_wr", 16'h00FF, 1, 1'b1);
    chk("lb_tx_valid", a_if.tx_valid, 0);
    chk("lb_tx_count", a_if.tx_count, 0);
    read_a("lb_rd", 16'h00FF, 0);
    chk("lb_tx_valid_after", a_if.tx_valid, 0);

    b_if.io_write = 1'b1; b_if.io_bus_out = 16'h0033;
    n = 0;
    while (!b_if.ioack && n < 12) begin @(negedge clk); n++; end
    chk("lb_b_wr_latency", n, 5);
    b_if.io_write = 1'b0;
    @(negedge clk); @(negedge clk);
    b_if.io_read = 1'b1;
    n = 0;
    while (!b_if.ioack && n < 12) begin @(negedge clk); n++; end
    chk("lb_b_rd_latency", n, 5);
    chk("lb_b_rd_data", b_if.io_bus_in, 16'h0033);
    b_if.io_read = 1'b0;
    @(negedge clk); @(negedge clk);

    write_a("lb_pre_rst", 16'h0066, 1, 1'b1);
`else
    rx_push_a(16'h1234);
    rx_push_a(16'hABCD);
    chk("rx_count_2", a_if.rx_count, 2);
    read_a("rd1", 16'h1234, 1);
    read_a("rd2", 16'hABCD, 0);

    a_if.io_read = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (a_if.ioack) seen = 1'b1; end
    chk("empty_no_ack", seen, 0);
    rx_push_a(16'h0042);
    n = 0;
    while (!a_if.ioack && n < 6) begin @(negedge clk); n++; end
    chk("late_ack", a_if.ioack, 1);
    chk("late_ack_wait", n, 1);
    chk("late_data", a_if.io_bus_in, 16'h0042);
    a_if.io_read = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("bus_in_held", a_if.io_bus_in, 16'h0042);

    for (int i = 0; i < 8; i++) write_a("wr", 16'(i), i + 1, 1'b0);
    a_if.io_write = 1'b1; a_if.io_bus_out = 16'd8;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (a_if.ioack) seen = 1'b1; end
    chk("full_stall", seen, 0);
    chk("full_count", a_if.tx_count, 8);
    chk("full_head", a_if.tx_data, 0);
    a_if.tx_ready = 1'b1;
    @(negedge clk);
    a_if.tx_ready = 1'b0;
    chk("pop_no_same_cycle_push", a_if.ioack, 0);
    chk("pop_count", a_if.tx_count, 7);
    n = 0;
    while (!a_if.ioack && n < 6) begin @(negedge clk); n++; end
    chk("ninth_ack", a_if.ioack, 1);
    chk("ninth_count", a_if.tx_count, 8);
    a_if.io_write = 1'b0;
    @(negedge clk); @(negedge clk);
    a_if.tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("stream_order", a_if.tx_data, i);
      @(negedge clk);
    end
    a_if.tx_ready = 1'b0;
    chk("drained_count", a_if.tx_count, 0);
    chk("drained_valid", a_if.tx_valid, 0);

    rx_push_a(16'h0005);
    a_if.io_read = 1'b1; a_if.io_write = 1'b1; a_if.io_bus_out = 16'h7777;
    @(negedge clk); @(negedge clk);
    chk("both_ack", a_if.ioack, 1);
    chk("both_data", a_if.io_bus_in, 16'h0005);
    a_if.io_read = 1'b0; a_if.io_write = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("both_tx_unchanged", a_if.tx_count, 0);

    b_if.rx_data = 16'h0099; b_if.rx_valid = 1'b1;
    @(negedge clk);
    b_if.rx_valid = 1'b0;
    b_if.io_read = 1'b1;
    n = 0;
    while (!b_if.ioack && n < 12) begin @(negedge clk); n++; end
    chk("delay3_latency", n, 5);
    chk("delay3_data", b_if.io_bus_in, 16'h0099);
    b_if.io_read = 1'b0;
    @(negedge clk); @(negedge clk);

    write_a("pre_rst_wr", 16'h0055, 1, 1'b0);
    rx_push_a(16'h0066);
`endif

    a_if.io_read = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_ack", a_if.ioack, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ack", a_if.ioack, 0);
    chk("rst_async_rxcnt", a_if.rx_count, 0);
    chk("rst_async_txcnt", a_if.tx_count, 0);
    chk("rst_async_txvalid", a_if.tx_valid, 0);
    a_if.io_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", a_if.ioack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
